// File: rtl/capture_seq_pkg.sv
// Shared definitions for the capture sequencer: FSM state encoding and seq_mode values.
package capture_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LATCH     = 3'd1,
        GAP       = 3'd2,
        ARM       = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5,
        NEXT      = 3'd6,
        FINISH    = 3'd7
    } seq_state_e;

    localparam logic SEQ_ALL = 1'b0;
    localparam logic SEQ_ONE = 1'b1;

endpackage

// File: rtl/capture_seq_prio_enc.sv
// Lowest-set-bit priority encoder; picks the next pending channel in one-at-a-time mode.
module capture_seq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic [4:0]   idx_o,
    output logic         valid_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = 5'd0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o = req_i[i] ? 5'(i) : idx_o;
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/capture_sequencer.sv
// Sequences arm strobes and tracks ack/done handshakes of N_CHAN capture channels.
// Optional CAPTURE_SEQ_REPEAT_EN adds repeat_count/rep_idx for multi-pass sequences.
module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int N_CHAN   = 8,
    parameter int TO_W     = 24,
    parameter int ARM_HOLD = 4,
    parameter int ARM_GAP  = 3
) (
    input  logic              clk40,
    input  logic              rstb,
    input  logic              start,
    input  logic              abort,
    input  logic              seq_mode,
    input  logic [N_CHAN-1:0] chan_mask,
    input  logic [TO_W-1:0]   timeout_cycles,
    input  logic [N_CHAN-1:0] waiting_for_trig_in,
    input  logic [N_CHAN-1:0] writing_in,
`ifdef CAPTURE_SEQ_REPEAT_EN
    input  logic [7:0]        repeat_count,
    output logic [7:0]        rep_idx,
`endif
    output logic [N_CHAN-1:0] aquire_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [N_CHAN-1:0] chan_done,
    output logic [N_CHAN-1:0] chan_timeout,
    output logic [4:0]        cur_chan
);

    localparam logic [N_CHAN-1:0] ZERO_C = {N_CHAN{1'b0}};

    seq_state_e        state_q, state_d;
    logic [N_CHAN-1:0] mask_q, pending_q, pending_d, acked_q, wr_seen_q;
    logic [N_CHAN-1:0] chan_done_q, chan_timeout_q, aquire_q, aquire_d;
    logic [N_CHAN-1:0] active_s, ack_now_s, fin_now_s, done_now_s, new_to_s;
    logic [TO_W-1:0]   to_q, cnt_q;
    logic [4:0]        cur_chan_q, cur_chan_d, enc_idx_s;
    logic              mode_q, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              enc_valid_s, in_wait_s, to_hit_s, abort_hit_s, final_s;

`ifdef CAPTURE_SEQ_REPEAT_EN
    logic [7:0] rep_q, rcount_q;

    // Pass counter: cleared at start, advanced on every repeat from FINISH.
    always_ff @(posedge clk40 or negedge rstb) begin
        if (!rstb) begin
            rep_q    <= 8'd0;
            rcount_q <= 8'd0;
        end else if (state_q == IDLE && state_d == LATCH) begin
            rep_q    <= 8'd0;
            rcount_q <= repeat_count;
        end else if (state_q == FINISH && state_d == GAP) begin
            rep_q    <= rep_q + 8'd1;
        end else begin
            rep_q    <= rep_q;
        end
    end

    assign final_s = (chan_timeout_q != ZERO_C) || (mask_q == ZERO_C) || (rep_q >= rcount_q);
    assign rep_idx = rep_q;
`else
    assign final_s = 1'b1;
`endif

    // Mode 1 arms the single channel named by cur_chan; mode 0 arms everything still pending.
    assign active_s    = (mode_q == SEQ_ONE) ? (N_CHAN'(1'b1) << cur_chan_q) : pending_q;
    assign in_wait_s   = (state_q == WAIT_ACK) || (state_q == WAIT_DONE);
    assign ack_now_s   = acked_q | ((waiting_for_trig_in | writing_in) & active_s);
    assign fin_now_s   = in_wait_s ? (wr_seen_q & ~writing_in & active_s & ~chan_timeout_q) : ZERO_C;
    assign done_now_s  = chan_done_q | fin_now_s;
    assign to_hit_s    = in_wait_s && (to_q != {TO_W{1'b0}}) &&
                         (({1'b0, cnt_q} + (TO_W + 1)'(1'b1)) == {1'b0, to_q});
    assign new_to_s    = to_hit_s ? (active_s & ~chan_timeout_q &
                         ~((state_q == WAIT_ACK) ? ack_now_s : done_now_s)) : ZERO_C;
    assign abort_hit_s = abort && (state_q != IDLE) && !((state_q == FINISH) && final_s);

    capture_seq_prio_enc #(.N(N_CHAN)) u_prio_enc (
        .req_i   (pending_d),
        .idx_o   (enc_idx_s),
        .valid_o (enc_valid_s)
    );

    // State register.
    always_ff @(posedge clk40 or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every active state.
    always_comb begin
        state_d = state_q;
        if (abort_hit_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = (start && !abort) ? LATCH : IDLE;
                LATCH:     state_d = (mask_q == ZERO_C) ? FINISH : GAP;
                GAP:       state_d = (cnt_q == TO_W'(ARM_GAP - 1)) ? ARM : GAP;
                ARM:       state_d = (cnt_q == TO_W'(ARM_HOLD - 1)) ? WAIT_ACK : ARM;
                WAIT_ACK:  state_d = ((active_s & ~(ack_now_s | chan_timeout_q | new_to_s)) == ZERO_C)
                                     ? WAIT_DONE : WAIT_ACK;
                WAIT_DONE: state_d = ((active_s & ~(done_now_s | chan_timeout_q | new_to_s)) == ZERO_C)
                                     ? NEXT : WAIT_DONE;
                NEXT:      state_d = ((mode_q == SEQ_ONE) && ((pending_q & ~active_s) != ZERO_C))
                                     ? GAP : FINISH;
                FINISH:    state_d = final_s ? IDLE : GAP;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Pending set: loaded at start and on each repeat, a finished channel drops out at NEXT.
    always_comb begin
        pending_d = pending_q;
        if (state_q == IDLE && state_d == LATCH) begin
            pending_d = chan_mask;
        end else if (state_q == FINISH && state_d == GAP) begin
            pending_d = mask_q;
        end else if (state_q == NEXT) begin
            pending_d = pending_q & ~active_s;
        end else begin
            pending_d = pending_q;
        end
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        aquire_d   = (state_d == ARM) ? (active_s & ~chan_timeout_q) : ZERO_C;
        busy_d     = (state_d != IDLE) && !((state_d == FINISH) && final_s);
        done_d     = (state_d == FINISH) && final_s && (chan_timeout_q == ZERO_C);
        error_d    = ((state_d == FINISH) && final_s && (chan_timeout_q != ZERO_C)) || abort_hit_s;
        cur_chan_d = 5'd0;
        if ((mode_q == SEQ_ONE) && enc_valid_s && (state_d != IDLE) &&
            (state_d != LATCH) && (state_d != FINISH)) begin
            cur_chan_d = enc_idx_s;
        end else begin
            cur_chan_d = 5'd0;
        end
    end

    // Latched configuration, per-channel handshake tracking and the phase counter.
    always_ff @(posedge clk40 or negedge rstb) begin
        if (!rstb) begin
            mask_q         <= ZERO_C;
            mode_q         <= SEQ_ALL;
            to_q           <= {TO_W{1'b0}};
            pending_q      <= ZERO_C;
            acked_q        <= ZERO_C;
            wr_seen_q      <= ZERO_C;
            chan_done_q    <= ZERO_C;
            chan_timeout_q <= ZERO_C;
            cnt_q          <= {TO_W{1'b0}};
        end else begin
            pending_q <= pending_d;
            if (state_q == IDLE && state_d == LATCH) begin
                mask_q         <= chan_mask;
                mode_q         <= seq_mode;
                to_q           <= timeout_cycles;
                chan_done_q    <= ZERO_C;
                chan_timeout_q <= ZERO_C;
            end else if (state_q == FINISH && state_d == GAP) begin
                chan_done_q    <= ZERO_C;
            end else begin
                chan_done_q    <= done_now_s;
                chan_timeout_q <= chan_timeout_q | new_to_s;
            end
            if (state_q == GAP) begin
                acked_q   <= ZERO_C;
                wr_seen_q <= ZERO_C;
            end else if (in_wait_s) begin
                acked_q   <= ack_now_s;
                wr_seen_q <= wr_seen_q | (writing_in & active_s);
            end else begin
                acked_q   <= acked_q;
                wr_seen_q <= wr_seen_q;
            end
            // Restart on every phase change, then saturate.
            if ((state_d != state_q) || (state_d == IDLE)) begin
                cnt_q <= {TO_W{1'b0}};
            end else if (cnt_q != {TO_W{1'b1}}) begin
                cnt_q <= cnt_q + TO_W'(1'b1);
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk40 or negedge rstb) begin
        if (!rstb) begin
            aquire_q   <= ZERO_C;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cur_chan_q <= 5'd0;
        end else begin
            aquire_q   <= aquire_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cur_chan_q <= cur_chan_d;
        end
    end

    assign aquire_out   = aquire_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign chan_done    = chan_done_q;
    assign chan_timeout = chan_timeout_q;
    assign cur_chan     = cur_chan_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized bench for capture_sequencer: behavioural channel responders plus an outcome model.
module tb_capture_sequencer;

    localparam int N    = 4;
    localparam int TO_W = 24;
    localparam int HOLD = 4;
    localparam int GAPC = 3;

    logic            clk40 = 1'b0;
    logic            rstb, start, abort, seq_mode;
    logic [N-1:0]    chan_mask, waiting, writing, aquire, chan_done, chan_timeout;
    logic [TO_W-1:0] timeout_cycles;
    logic            busy, done, error;
    logic [4:0]      cur_chan;
`ifdef CAPTURE_SEQ_REPEAT_EN
    logic [7:0]      repeat_count, rep_idx;
`endif

    always #5 clk40 = ~clk40;

    capture_sequencer #(.N_CHAN(N), .TO_W(TO_W), .ARM_HOLD(HOLD), .ARM_GAP(GAPC)) dut (
        .clk40               (clk40),
        .rstb                (rstb),
        .start               (start),
        .abort               (abort),
        .seq_mode            (seq_mode),
        .chan_mask           (chan_mask),
        .timeout_cycles      (timeout_cycles),
        .waiting_for_trig_in (waiting),
        .writing_in          (writing),
`ifdef CAPTURE_SEQ_REPEAT_EN
        .repeat_count        (repeat_count),
        .rep_idx             (rep_idx),
`endif
        .aquire_out          (aquire),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .chan_done           (chan_done),
        .chan_timeout        (chan_timeout),
        .cur_chan            (cur_chan)
    );

    int           n_vec = 0, n_err = 0, cyc = 0;
    int           ch_t[N], ch_dly[N], ch_wlen[N];
    logic [N-1:0] alive = '0, aq_prev = '0, cto_prev = '0;
    int           hi_run = 0, lo_run = 0, fall_cyc = 0, to_cur = 0;
    int           done_pulses = 0, err_pulses = 0;
    bit           arm_chk_en = 1'b0, mode_cur = 1'b0;
    logic [N-1:0] arm_obs[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: sample outputs on the falling edge, update monitors, then drive channel responses.
    task automatic step();
        int idx;
        @(negedge clk40);
        cyc++;
        if (done)  done_pulses++;
        if (error) err_pulses++;
        if (aquire != '0 && aq_prev == '0) begin
            arm_obs.push_back(aquire);
            idx = 0;
            for (int i = N - 1; i >= 0; i--) if (aquire[i]) idx = i;
            if (arm_chk_en) begin
                check_eq("arm_gap_low_cycles", 32'(lo_run >= GAPC), 32'd1);
                check_eq("cur_chan_at_arm", 32'(cur_chan), mode_cur ? 32'(idx) : 32'd0);
            end
            hi_run = 0;
        end
        if (aquire != '0) hi_run++;
        if (aquire == '0 && aq_prev != '0) begin
            if (arm_chk_en) check_eq("arm_hold_cycles", 32'(hi_run), 32'(HOLD));
            fall_cyc = cyc;
            lo_run   = 0;
        end
        if (aquire == '0) lo_run++;
        if (arm_chk_en && ((chan_timeout & ~cto_prev) != '0))
            check_eq("timeout_latency", 32'(cyc - fall_cyc), 32'(to_cur));
        for (int i = 0; i < N; i++) begin
            if (aquire[i] && !aq_prev[i] && alive[i]) ch_t[i] = 0;
            else if (ch_t[i] >= 0) ch_t[i]++;
            waiting[i] = (ch_t[i] >= ch_dly[i]) && (ch_t[i] < ch_dly[i] + 2);
            writing[i] = (ch_t[i] >= ch_dly[i] + 2) && (ch_t[i] < ch_dly[i] + 2 + ch_wlen[i]);
            if (ch_t[i] >= ch_dly[i] + 2 + ch_wlen[i]) ch_t[i] = -1;
        end
        aq_prev  = aquire;
        cto_prev = chan_timeout;
    endtask

    task automatic setup_chans(input logic [N-1:0] live, input int wmin);
        alive = live;
        for (int i = 0; i < N; i++) begin
            ch_dly[i]  = 5 + int'($urandom_range(0, 5));
            ch_wlen[i] = wmin + int'($urandom_range(0, 20));
            ch_t[i]    = -1;
        end
    endtask

    // Full sequence against the outcome model: armed sets, sticky flags and the final pulse.
    task automatic run_seq(input logic [N-1:0] mask, input bit mode, input int to,
                           input logic [N-1:0] live, input bit poke);
        logic [N-1:0] exp_arm[$];
        int lat;
        if (mask != '0) begin
            if (!mode) exp_arm.push_back(mask);
            else for (int i = 0; i < N; i++) if (mask[i]) exp_arm.push_back(N'(1) << i);
        end
        setup_chans(live, 10);
        arm_obs.delete();
        done_pulses = 0; err_pulses = 0;
        to_cur = to; mode_cur = mode; arm_chk_en = 1'b1;
        chan_mask = mask; seq_mode = mode; timeout_cycles = TO_W'(to);
        start = 1'b1; lo_run = 0;
        step();
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        lat = 1;
        while ((done_pulses + err_pulses) == 0 && lat < 3000) begin
            if (poke && lat == 8) begin
                start = 1'b1; chan_mask = ~mask;
            end
            step();
            lat++;
            start = 1'b0; chan_mask = mask;
        end
        check_eq("sequence_ends", 32'((done_pulses + err_pulses) != 0), 32'd1);
        check_eq("busy_at_end_pulse", 32'(busy), 32'd0);
        if (mask == '0) check_eq("empty_mask_latency", 32'(lat), 32'd2);
        repeat (3) step();
        check_eq("done_pulses", 32'(done_pulses), 32'((mask & ~live) == '0));
        check_eq("error_pulses", 32'(err_pulses), 32'((mask & ~live) != '0));
        check_eq("chan_done", 32'(chan_done), 32'(mask & live));
        check_eq("chan_timeout", 32'(chan_timeout), 32'(mask & ~live));
        check_eq("arm_count", 32'(arm_obs.size()), 32'(exp_arm.size()));
        for (int i = 0; i < exp_arm.size() && i < arm_obs.size(); i++)
            check_eq("arm_set", 32'(arm_obs[i]), 32'(exp_arm[i]));
        check_eq("idle_outputs", {27'd0, busy, aquire}, 32'd0);
    endtask

    // Abort during ARM or during WAIT_DONE, with start raised in the same cycle.
    task automatic run_abort(input bit in_arm);
        int guard;
        setup_chans(4'b0011, 40);
        arm_chk_en = 1'b0; done_pulses = 0; err_pulses = 0;
        chan_mask = 4'b0011; seq_mode = 1'b0; timeout_cycles = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while ((in_arm ? (aquire == '0) : (writing == '0)) && guard < 200) begin
            step(); guard++;
        end
        check_eq("abort_reach_phase", 32'(guard < 200), 32'd1);
        if (!in_arm) repeat (2) step();
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check_eq("abort_aquire_low", 32'(aquire), 32'd0);
        check_eq("abort_error_pulse", 32'(error), 32'd1);
        check_eq("abort_busy_low", 32'(busy), 32'd0);
        repeat (5) step();
        check_eq("abort_stays_idle", 32'(busy), 32'd0);
        check_eq("abort_pulse_counts", {done_pulses[15:0], err_pulses[15:0]}, 32'h0000_0001);
        check_eq("abort_sticky_flags", {chan_done, chan_timeout}, 32'd0);
        repeat (60) step();
    endtask

    initial begin
        logic [N-1:0] m, lv;
        bit md;
        int to;
        rstb = 1'b0; start = 1'b0; abort = 1'b0; seq_mode = 1'b0;
        chan_mask = '0; timeout_cycles = '0; waiting = '0; writing = '0;
`ifdef CAPTURE_SEQ_REPEAT_EN
        repeat_count = 8'd0;
`endif
        for (int i = 0; i < N; i++) begin ch_t[i] = -1; ch_dly[i] = 5; ch_wlen[i] = 10; end
        repeat (3) step();
        check_eq("reset_outputs",
                 {16'd0, aquire, chan_done, chan_timeout, busy, done, error, 1'b0},
                 32'd0);
        check_eq("reset_cur_chan", 32'(cur_chan), 32'd0);
        rstb = 1'b1;
        step();
        // start and abort together from IDLE must not launch a sequence
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        check_eq("start_with_abort_ignored", {30'd0, busy, error}, 32'd0);

        run_seq(4'b1011, 1'b0, 100, 4'b1111, 1'b0);
        run_seq(4'b1011, 1'b1, 100, 4'b1111, 1'b1);
        run_seq(4'b0001, 1'b0, 50, 4'b0000, 1'b0);
        run_seq(4'b0000, 1'b0, 0, 4'b1111, 1'b0);
        run_seq(4'b0110, 1'b1, 45, 4'b0100, 1'b0);
        run_seq(4'b1111, 1'b0, 0, 4'b1111, 1'b1);
        run_abort(1'b0);
        run_abort(1'b1);

        for (int k = 0; k < 16; k++) begin
            m  = N'($urandom_range(0, 15));
            md = 1'($urandom_range(0, 1));
            lv = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : 4'b1111;
            if ((m & ~lv) != '0) to = 40 + int'($urandom_range(0, 40));
            else to = ($urandom_range(0, 1) == 1) ? 0 : 60 + int'($urandom_range(0, 40));
            run_seq(m, md, to, lv, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while channel 1 is being armed in one-at-a-time mode
        setup_chans(4'b1111, 10);
        arm_chk_en = 1'b0;
        chan_mask = 4'b1111; seq_mode = 1'b1; timeout_cycles = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        to = 0;
        while (!(aquire == 4'b0010) && to < 500) begin step(); to++; end
        check_eq("reset_reach_chan1", 32'(to < 500), 32'd1);
        rstb = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 {16'd0, aquire, chan_done, chan_timeout, busy, done, error, 1'b0},
                 32'd0);
        check_eq("async_reset_cur_chan", 32'(cur_chan), 32'd0);
        repeat (2) step();
        rstb = 1'b1;
        repeat (60) step();
        run_seq(4'b0101, 1'b1, 0, 4'b1111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences the acquisition strobes of N_CHAN link-capture channels from one 40 MHz control domain.
- Latches a start request and channel mask, then drives each channel's aquire input.
- Tracks each channel's handshake: waiting_for_trig or writing rises, then writing falls.
- Reports per-channel done/timeout plus overall busy/done/error. Sits between the AXI control registers and the per-link capture BRAM controllers.

Parameters:
- N_CHAN, 8, number of capture channels (1..32).
- TO_W, 24, width of the timeout counter and timeout_cycles port.
- ARM_HOLD, 4, clk40 cycles aquire_out is held high per arm (>=1).
- ARM_GAP, 3, minimum clk40 cycles aquire_out is low before a re-arm (>=2).

Ports:
- clk40  in  1  control clock, 40 MHz
- rstb  in  1  asynchronous active-low reset
- start  in  1  single-cycle start request, ignored while busy
- abort  in  1  level; forces return to IDLE
- seq_mode  in  1  0 = all masked channels armed together, 1 = masked channels armed one at a time, ascending index
- chan_mask  in  N_CHAN  channels taking part, latched at start
- timeout_cycles  in  TO_W  per-phase timeout, latched at start; 0 = no timeout
- waiting_for_trig_in  in  N_CHAN  from capture channels
- writing_in  in  N_CHAN  from capture channels
- aquire_out  out  N_CHAN  arm strobe to capture channels
- busy  out  1  high from the cycle after accepted start until done/error
- done  out  1  one-cycle pulse, sequence completed with no timeout
- error  out  1  one-cycle pulse, sequence ended with >=1 timeout or abort
- chan_done  out  N_CHAN  sticky per channel, cleared at accepted start
- chan_timeout  out  N_CHAN  sticky per channel, cleared at accepted start
- cur_chan  out  5  active channel index in seq_mode 1; 0 otherwise

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0.
- IDLE: start=1 and abort=0 -> LATCH. Latch mask, mode and timeout. Clear chan_done and chan_timeout.
- LATCH -> if mask==0: pulse done next cycle, back to IDLE. Otherwise -> GAP.
- GAP: aquire_out=0 for ARM_GAP cycles, so the target's 3-bit edge detector sees 0,0,1. Then -> ARM.
- ARM: assert aquire_out on the active set for ARM_HOLD cycles. Active set = whole mask in mode 0, lowest pending channel in mode 1. Then -> WAIT_ACK.
- WAIT_ACK: a channel is acked once (waiting_for_trig_in | writing_in) is seen high. When every active channel is acked or timed out -> WAIT_DONE.
- WAIT_DONE: a channel is done when writing_in has been seen high and is then seen low. Set chan_done at that point.
  - A channel whose writing_in rose and fell entirely inside WAIT_ACK is also done.
  - When every active channel is done or timed out -> NEXT.
- Timeout counter: reset on entry to WAIT_ACK and to WAIT_DONE, counts up each cycle.
  - When it equals timeout_cycles (nonzero), set chan_timeout for every active channel still not acked/done.
  - That channel's aquire stays low. It is skipped for the rest of the sequence.
- NEXT: mode 1 with pending channels remaining -> GAP (cur_chan advances to next set mask bit). Otherwise -> FINISH.
- FINISH: pulse done if chan_timeout==0, else pulse error. busy=0. -> IDLE.
- abort in any non-IDLE state: aquire_out=0 immediately (next cycle), pulse error, -> IDLE. Sticky flags keep their values.
- start while busy is ignored. start and abort in the same cycle: abort wins.
- Reset mid-sequence: asynchronous return to IDLE, aquire_out=0.
- Counters saturate; no wrap at 2^TO_W-1.

Optional Feature:
- Macro CAPTURE_SEQ_REPEAT_EN.
- Defined: adds input repeat_count[7:0] (latched at start) and output rep_idx[7:0].
  - FINISH with no timeout and rep_idx<repeat_count -> increment rep_idx, clear chan_done, -> GAP with the full latched mask.
  - done pulses only after the final pass. repeat_count=0 means one pass.
- Undefined: single pass; port absent.

Decomposition:
- Package capture_seq_pkg holds:
  - state enum (IDLE, LATCH, GAP, ARM, WAIT_ACK, WAIT_DONE, NEXT, FINISH);
  - seq_mode constants SEQ_ALL=0 and SEQ_ONE=1.
- One sub-module: capture_seq_prio_enc. It finds the lowest set bit of the pending mask and returns its index plus a valid flag; used for cur_chan selection.

Test Plan:
- N_CHAN=4, mask=4'b1011, seq_mode=0, timeout=100; model channels with waiting_for_trig 5 cycles after the aquire edge and writing for 20 cycles -> aquire_out=1011 for 4 cycles after 3-cycle gap, chan_done=1011, done pulse, error 0.
- Same mask, seq_mode=1 -> channels 0,1,3 armed in order, cur_chan 0->1->3, each aquire preceded by >=3 low cycles, single done.
- mask=0001, channel never responds, timeout=50 -> chan_timeout[0]=1 exactly 50 cycles after WAIT_ACK entry, error pulse, no done.
- abort asserted mid-WAIT_DONE -> aquire_out=0 next cycle, error pulse, busy=0, FSM IDLE. start in the same cycle as abort is ignored.
- start pulsed while busy, and mask=0 start -> first ignored, second gives done one cycle after LATCH with no aquire activity.
- With CAPTURE_SEQ_REPEAT_EN, repeat_count=2 -> three arm passes, rep_idx 0,1,2, one done at end. Deassert rstb during pass 2 -> all outputs 0 immediately.
